rst_seq_ctrl: RTL
=================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, number of staged reset outputs (1..8).
REQ-002 SHALL have parameter HOLD_CYC, default 16, minimum cycles all resets stay asserted after any restart cause.
REQ-003 SHALL have parameter STAGE_CYC, default 8, cycles between successive stage releases.
REQ-004 SHALL have parameter DB_CYC, default 1024, debounce stability window in cycles.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high block reset.
REQ-007 SHALL have port btn_n  input  1  asynchronous push-button, active-low restart request.
REQ-008 SHALL have port pll_locked  input  1  asynchronous clock-source lock indicator.
REQ-009 SHALL have port sw_rst  input  1  synchronous single-cycle software restart pulse.
REQ-010 SHALL have port rst_n  output  NSTAGE  staged active-low resets, bit 0 released first.
REQ-011 SHALL have port done  output  1  high while all stages released (RUN).
REQ-012 SHALL have port restart_cnt  output  8  count of restarts since reset, saturating.

Function
REQ-013 SHALL synchronise btn_n and pll_locked through two flops each (reset values 1 and 0 respectively).
REQ-014 SHALL emit a one-cycle btn_req when synchronised btn_n has been low DB_CYC consecutive cycles; SHALL re-arm only after DB_CYC consecutive high cycles.
REQ-015 SHALL implement FSM states HOLD, WAIT_LOCK, REL, RUN.
REQ-016 HOLD: all rst_n low; counter runs HOLD_CYC cycles, then -> WAIT_LOCK.
REQ-017 WAIT_LOCK: all rst_n low; -> REL on first cycle synchronised lock is high (minimum one cycle in state).
REQ-018 REL: stage index s from 0; every STAGE_CYC cycles rst_n[s] goes high and s increments; when rst_n[NSTAGE-1] rises -> RUN same edge.
REQ-019 RUN: done high, all rst_n high, held until a restart cause.
REQ-020 Restart cause = btn_req, sw_rst, or synchronised lock low while in REL or RUN.
REQ-021 On restart cause in REL or RUN, all rst_n SHALL go low on the next edge, s and counters clear, state -> HOLD, restart_cnt increments once.
REQ-022 Simultaneous restart causes in one cycle SHALL count as one restart.
REQ-023 btn_req or sw_rst in HOLD or WAIT_LOCK SHALL restart the HOLD count without incrementing restart_cnt.
REQ-024 restart_cnt SHALL saturate at 255.
REQ-025 rst_n, done SHALL be registered outputs; done low in every state except RUN.
REQ-026 With lock stable high before reset release and defaults, rst_n[k] SHALL rise on edge 25+8k after reset deasserts (edge 1 = first edge).

Reset
REQ-027 reset high SHALL asynchronously force rst_n all 0, done 0, restart_cnt 0, state HOLD, all counters and s 0, debounce disarmed-idle.
REQ-028 reset asserted mid-REL or RUN SHALL produce the same result as power-up; no partial stage state retained.
REQ-029 Release of reset SHALL be treated as restart from HOLD per REQ-016.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the FSM state enum and restart_cnt width constant.
REQ-031 Debounce plus button synchroniser SHALL be sub-module btn_debounce (params DB_CYC; ports clk, reset, btn_n, btn_req).
REQ-032 Counter widths SHALL derive from $clog2 of the respective parameter.

Verification
REQ-033 Lock high throughout, reset released -> rst_n 000, 001 at edge 25, 011 at 33, 111 at 41, done at 41.
REQ-034 Lock held low 100 cycles after reset -> rst_n stays 000 in WAIT_LOCK; lock rises -> rst_n[0] high 8+sync cycles later.
REQ-035 In RUN, btn_n low 1030 cycles -> single btn_req, rst_n 000 next edge, restart_cnt 1; bounce shorter than 1024 -> no effect.
REQ-036 In REL after rst_n=001, pll_locked drops -> rst_n 000, state HOLD, restart_cnt +1.
REQ-037 sw_rst and lock loss same cycle in RUN -> restart_cnt +1 only; 300 sw_rst restarts -> restart_cnt 255.
REQ-038 reset pulse mid-REL -> all outputs to reset values immediately, full sequence repeats per REQ-033.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_REL       = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int RCNT_W = 8;
  localparam logic [RCNT_W-1:0] RCNT_MAX = '1;

  function automatic logic [RCNT_W-1:0] sat_inc(input logic [RCNT_W-1:0] v);
    return (v == RCNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Restart inputs and staged reset outputs of the reset sequencer.
interface rst_seq_ctrl_if #(
  parameter int NSTAGE = 3
);
  import rst_seq_pkg::*;

  logic              btn_n;
  logic              pll_locked;
  logic              sw_rst;
  logic [NSTAGE-1:0] rst_n;
  logic              done;
  logic [RCNT_W-1:0] restart_cnt;

  modport master (
    output btn_n, pll_locked, sw_rst,
    input  rst_n, done, restart_cnt
  );

  modport slave (
    input  btn_n, pll_locked, sw_rst,
    output rst_n, done, restart_cnt
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer: one btn_req pulse per stable press,
// re-armed only after the button has been stably released.
module btn_debounce #(
  parameter int DB_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_req
);
  localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic            r_s1;
  logic            r_s2;
  logic            r_armed;
  logic            r_req;
  logic [DB_W-1:0] r_cnt;
  logic            w_match;

  // Armed waits for a stable low level, disarmed waits for a stable high level.
  assign w_match = r_armed ? ~r_s2 : r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_s1  <= btn_n;
      r_s2  <= r_s1;
      r_req <= 1'b0;
      if (!w_match) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_W'(DB_CYC - 1)) begin
        r_cnt   <= '0;
        r_armed <= ~r_armed;
        r_req   <= r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_req = r_req;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds all downstream resets, waits for clock lock,
// then releases one stage at a time and watches for restart causes.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NSTAGE    = 3,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 8,
  parameter int DB_CYC    = 1024
) (
  input logic           clk,
  input logic           reset,
  rst_seq_ctrl_if.slave bus
);
  localparam int HOLD_W = (HOLD_CYC > 1)  ? $clog2(HOLD_CYC)  : 1;
  localparam int STG_W  = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
  localparam int S_W    = (NSTAGE > 1)    ? $clog2(NSTAGE)    : 1;

  state_e            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [STG_W-1:0]  r_stg_cnt;
  logic [S_W-1:0]    r_s;
  logic [NSTAGE-1:0] r_rst_n;
  logic              r_done;
  logic [RCNT_W-1:0] r_restart_cnt;
  logic              r_lk_s1;
  logic              r_lk_s2;

  state_e            w_state_nx;
  logic [HOLD_W-1:0] w_hold_nx;
  logic [STG_W-1:0]  w_stg_nx;
  logic [S_W-1:0]    w_s_nx;
  logic [NSTAGE-1:0] w_rst_n_nx;
  logic              w_done_nx;
  logic              w_btn_req;
  logic              w_req;
  logic              w_restart;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (bus.btn_n),
    .btn_req (w_btn_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lk_s1 <= 1'b0;
      r_lk_s2 <= 1'b0;
    end else begin
      r_lk_s1 <= bus.pll_locked;
      r_lk_s2 <= r_lk_s1;
    end
  end

  // Lock loss only matters once stages have started to come out of reset.
  assign w_req     = w_btn_req | bus.sw_rst;
  assign w_restart = ((r_state == ST_REL) || (r_state == ST_RUN)) && (w_req || !r_lk_s2);

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold_cnt;
    w_stg_nx   = r_stg_cnt;
    w_s_nx     = r_s;
    w_rst_n_nx = r_rst_n;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_rst_n_nx = '0;
        if (w_req) begin
          w_hold_nx = '0;
        end else if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
          w_hold_nx  = '0;
          w_state_nx = ST_WAIT_LOCK;
        end else begin
          w_hold_nx = r_hold_cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        w_rst_n_nx = '0;
        if (w_req) begin
          w_state_nx = ST_HOLD;
        end else if (r_lk_s2) begin
          w_state_nx = ST_REL;
          w_stg_nx   = '0;
          w_s_nx     = '0;
        end
      end
      ST_REL: begin
        if (r_stg_cnt == STG_W'(STAGE_CYC - 1)) begin
          w_stg_nx        = '0;
          w_rst_n_nx[r_s] = 1'b1;
          if (r_s == S_W'(NSTAGE - 1)) begin
            w_state_nx = ST_RUN;
            w_done_nx  = 1'b1;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end else begin
          w_stg_nx = r_stg_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_done_nx = 1'b1;
      end
      default: begin
        w_state_nx = ST_HOLD;
        w_rst_n_nx = '0;
      end
    endcase
    if (w_restart) begin
      w_state_nx = ST_HOLD;
      w_hold_nx  = '0;
      w_stg_nx   = '0;
      w_s_nx     = '0;
      w_rst_n_nx = '0;
      w_done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_HOLD;
      r_hold_cnt    <= '0;
      r_stg_cnt     <= '0;
      r_s           <= '0;
      r_rst_n       <= '0;
      r_done        <= 1'b0;
      r_restart_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_hold_cnt <= w_hold_nx;
      r_stg_cnt  <= w_stg_nx;
      r_s        <= w_s_nx;
      r_rst_n    <= w_rst_n_nx;
      r_done     <= w_done_nx;
      if (w_restart) begin
        r_restart_cnt <= sat_inc(r_restart_cnt);
      end
    end
  end

  assign bus.rst_n       = r_rst_n;
  assign bus.done        = r_done;
  assign bus.restart_cnt = r_restart_cnt;

endmodule
